// File: rtl/phase_packet_arbiter_pkg.sv
`timescale 1ns/1ps
// Shared types for the phase packet arbiter and its skid register.
// No logic; default geometry constants plus the arbiter state encoding.
// Backpressure: not applicable.
package phase_pkg;

    localparam int DATA_WIDTH_DEF   = 16;
    localparam int BEAT_SIZE_DEF    = 8;
    localparam int TAG_CATAGORY_DEF = 4;

    // Width of a source index; a single-source build still needs one bit.
    function automatic int src_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int SRC_W = src_width(TAG_CATAGORY_DEF);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef logic [BEAT_SIZE_DEF*DATA_WIDTH_DEF-1:0] beat_t;

endpackage

// File: rtl/phase_packet_arbiter_axis_skid_reg.sv
`timescale 1ns/1ps
// Two-entry fully registered valid/ready pipeline stage for an opaque payload.
// Latency: 1 cycle from input handshake to output valid.
// Backpressure: ready is registered; a second entry absorbs the beat in flight.
module axis_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         s_vld_i,
    output logic         s_rdy_o,
    input  logic [W-1:0] s_dat_i,
    output logic         m_vld_o,
    input  logic         m_rdy_i,
    output logic [W-1:0] m_dat_o
);

    logic         main_vld_q;
    logic         skid_vld_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;

    // Ready only depends on the spare entry being free, so it is a flop output.
    assign s_rdy_o = !skid_vld_q;
    assign m_vld_o = main_vld_q;
    assign m_dat_o = main_q;

    // Output entry refills from the spare first, else from the input; spare catches a stalled beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (m_rdy_i || !main_vld_q) begin
            if (skid_vld_q) begin
                main_q     <= skid_q;
                main_vld_q <= 1'b1;
                skid_vld_q <= 1'b0;
            end else begin
                main_vld_q <= s_vld_i;
                if (s_vld_i) begin
                    main_q <= s_dat_i;
                end
            end
        end else if (s_vld_i && !skid_vld_q) begin
            skid_q     <= s_dat_i;
            skid_vld_q <= 1'b1;
        end
    end

endmodule

// File: rtl/phase_packet_arbiter.sv
`timescale 1ns/1ps
// Packet-granular round-robin merge of N phase sources onto one stream, tagging each packet with its source.
// Latency: 1 idle arbitration cycle per packet, then 1 registered cycle input-to-output.
// Backpressure: only the granted source sees ready; PKT_LEN_CHECK_EN adds a per-packet length guard.
module phase_packet_arbiter
    import phase_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int BEAT_SIZE    = 8,
    parameter int TAG_WIDTH    = 8,
    parameter int TAG_CATAGORY = 4,
    parameter int PKT_BEATS    = 256
) (
    input  logic                                         aclk,
    input  logic                                         aresetn,
    input  logic [TAG_CATAGORY*BEAT_SIZE*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [TAG_CATAGORY-1:0]                      s_axis_tvalid,
    output logic [TAG_CATAGORY-1:0]                      s_axis_tready,
    input  logic [TAG_CATAGORY-1:0]                      s_axis_tlast,
    output logic [BEAT_SIZE*DATA_WIDTH-1:0]              m_axis_tdata,
    output logic                                         m_axis_tvalid,
    input  logic                                         m_axis_tready,
    output logic                                         m_axis_tlast,
    output logic [TAG_WIDTH-1:0]                         m_axis_tuser,
    output logic                                         pkt_err
);

    localparam int BW = BEAT_SIZE * DATA_WIDTH;
    localparam int N  = TAG_CATAGORY;
    localparam int SW = src_width(TAG_CATAGORY);
    localparam int PW = BW + 1 + TAG_WIDTH;

    if (TAG_CATAGORY < 2 || TAG_CATAGORY > 16 || PKT_BEATS < 1) begin : g_bad_param
        $error("phase_packet_arbiter: unsupported parameter set");
    end

    arb_state_t    state_q;
    logic [SW-1:0] grant_q;
    logic [SW-1:0] rr_q;
    logic          pick_hit;
    logic [SW-1:0] pick_idx;
    logic          skid_rdy;
    logic          src_vld;
    logic          accept;
    logic          src_last;
    logic          force_last;
    logic          pkt_end;
    logic [PW-1:0] skid_in;
    logic [PW-1:0] skid_out;

    // First requester at or after ptr, wrapping; descending scan lets the nearest one win.
    function automatic logic [SW:0] rr_pick(input logic [N-1:0] req, input logic [SW-1:0] ptr);
        logic [SW:0] res;
        int          idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                res = {1'b1, idx[SW-1:0]};
            end
        end
        return res;
    endfunction

    assign {pick_hit, pick_idx} = rr_pick(s_axis_tvalid, rr_q);

    assign src_vld  = (state_q == BUSY) && s_axis_tvalid[grant_q];
    assign accept   = src_vld && skid_rdy;
    assign src_last = s_axis_tlast[grant_q] | force_last;
    assign pkt_end  = accept && src_last;
    assign skid_in  = {s_axis_tdata[int'(grant_q)*BW +: BW], src_last, TAG_WIDTH'(grant_q)};

    // Only the locked source is offered ready, and only while a packet is in progress.
    always_comb begin
        s_axis_tready = '0;
        if (state_q == BUSY) begin
            s_axis_tready[grant_q] = skid_rdy;
        end
    end

    // Arbitration FSM: lock a grant in IDLE, release it and advance the pointer at end of packet.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_hit) begin
                        grant_q <= pick_idx;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (pkt_end) begin
                        state_q <= IDLE;
                        rr_q    <= (int'(grant_q) == N - 1) ? '0 : grant_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef PKT_LEN_CHECK_EN
    localparam int CW = $clog2(PKT_BEATS) + 1;

    logic [CW-1:0] beat_cnt_q;
    logic          pkt_err_q;
    logic          at_limit;

    // Current beat is the last one a well-formed packet may carry.
    assign at_limit   = (beat_cnt_q == CW'(PKT_BEATS - 1));
    assign force_last = at_limit;
    assign pkt_err    = pkt_err_q;

    // Count beats of the granted packet; flag any tlast/limit disagreement until reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt_q <= '0;
            pkt_err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                beat_cnt_q <= '0;
            end else if (accept) begin
                beat_cnt_q <= pkt_end ? '0 : beat_cnt_q + 1'b1;
            end
            if (accept && (s_axis_tlast[grant_q] != at_limit)) begin
                pkt_err_q <= 1'b1;
            end
        end
    end
`else
    assign force_last = 1'b0;
    assign pkt_err    = 1'b0;
`endif

    axis_skid_reg #(
        .W (PW)
    ) u_skid (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .s_vld_i (src_vld),
        .s_rdy_o (skid_rdy),
        .s_dat_i (skid_in),
        .m_vld_o (m_axis_tvalid),
        .m_rdy_i (m_axis_tready),
        .m_dat_o (skid_out)
    );

    assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = skid_out;

endmodule

// File: tb/tb_phase_packet_arbiter.sv
`timescale 1ns/1ps
// Directed bench for phase_packet_arbiter: arbitration order, latency, backpressure, reset, length guard.
// Sources and sink are modelled cycle by cycle in one process; outputs are sampled on the falling edge.
// Backpressure: the sink can toggle ready every cycle.
module tb_phase_packet_arbiter;

    localparam int N  = 4;
    localparam int BW = 128;
    localparam int TW = 8;
    localparam logic [BW-1:0] BP_PAT = {4{32'h00010203}};

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [N*BW-1:0] s_tdata = '0;
    logic [N-1:0]    s_tvalid = '0;
    logic [N-1:0]    s_tready;
    logic [N-1:0]    s_tlast = '0;
    logic [BW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready = 1'b1;
    logic            m_tlast;
    logic [TW-1:0]   m_tuser;
    logic            pkt_err;

    always #5 aclk = ~aclk;

    phase_packet_arbiter #(
        .DATA_WIDTH   (16),
        .BEAT_SIZE    (8),
        .TAG_WIDTH    (TW),
        .TAG_CATAGORY (N),
        .PKT_BEATS    (256)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .pkt_err       (pkt_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit en[N];
    bit tl_en[N];
    bit pat_mode[N];
    int total[N];
    int plen[N];
    int sent[N];
    int val[N];
    bit bp = 1'b0;

    logic [BW-1:0] oq_dat[$];
    bit            oq_last[$];
    logic [TW-1:0] oq_user[$];
    int            oq_cyc[$];

    int            stall_viol = 0;
    int            multi_rdy  = 0;
    bit            prev_stall = 1'b0;
    logic [BW-1:0] held_dat;
    logic          held_last;
    logic [TW-1:0] held_user;

    function automatic logic [BW-1:0] rep16(input int v);
        logic [BW-1:0] r;
        for (int j = 0; j < 8; j++) r[j*16 +: 16] = 16'(v);
        return r;
    endfunction

    // One clock of source/sink modelling: sample at negedge, update drives just after posedge.
    task automatic step();
        logic [N-1:0] fire;
        @(negedge aclk);
        if (m_tvalid && m_tready) begin
            oq_dat.push_back(m_tdata);
            oq_last.push_back(m_tlast);
            oq_user.push_back(m_tuser);
            oq_cyc.push_back(cyc);
        end
        if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== held_dat ||
                           m_tlast !== held_last || m_tuser !== held_user))
            stall_viol++;
        prev_stall = m_tvalid && !m_tready;
        held_dat   = m_tdata;
        held_last  = m_tlast;
        held_user  = m_tuser;
        if ($countones(s_tready) > 1) multi_rdy++;
        fire = s_tvalid & s_tready;
        @(posedge aclk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) sent[i]++;
            s_tvalid[i] = en[i] && (sent[i] < total[i]);
            s_tlast[i]  = s_tvalid[i] && tl_en[i] && (((sent[i] + 1) % plen[i]) == 0);
            s_tdata[i*BW +: BW] = pat_mode[i] ? BP_PAT : rep16(val[i]);
        end
        m_tready = bp ? ~m_tready : 1'b1;
    endtask

    task automatic run_until(input int nbeats, input int budget);
        for (int k = 0; k < budget && oq_dat.size() < nbeats; k++) step();
    endtask

    task automatic clear_out();
        oq_dat.delete();
        oq_last.delete();
        oq_user.delete();
        oq_cyc.delete();
    endtask

    task automatic set_src(input int i, input int tot, input int len, input int v,
                           input bit tl, input bit mode);
        total[i]    = tot;
        plen[i]     = len;
        val[i]      = v;
        tl_en[i]    = tl;
        pat_mode[i] = mode;
        sent[i]     = 0;
        en[i]       = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid got %b want 0", m_tvalid); end
        n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL rst_tlast got %b want 0", m_tlast); end
        n_cmp++; if (m_tdata !== '0) begin n_bad++; $display("FAIL rst_tdata got %h want 0", m_tdata); end
        n_cmp++; if (m_tuser !== '0) begin n_bad++; $display("FAIL rst_tuser got %h want 0", m_tuser); end
        n_cmp++; if (s_tready !== '0) begin n_bad++; $display("FAIL rst_tready got %b want 0", s_tready); end
        n_cmp++; if (pkt_err !== 1'b0) begin n_bad++; $display("FAIL rst_pkt_err got %b want 0", pkt_err); end
        aresetn = 1'b1;
        repeat (3) step();
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL idle_tvalid got %b want 0", m_tvalid); end
    endtask

    task automatic test_round_robin();
        int bu, bd, bl, bg, g;
        clear_out();
        multi_rdy = 0;
        for (int k = 0; k < N; k++) set_src(k, 256, 256, k + 1, 1'b1, 1'b0);
        run_until(1024, 1500);
        n_cmp++; if (oq_dat.size() != 1024) begin n_bad++; $display("FAIL rr_count got %0d want 1024", oq_dat.size()); end
        bu = 0; bd = 0; bl = 0; bg = 0;
        for (int b = 0; b < oq_dat.size(); b++) begin
            if (oq_user[b] !== TW'(b / 256)) bu++;
            if (oq_dat[b] !== rep16(b / 256 + 1)) bd++;
            if (oq_last[b] != ((b % 256) == 255)) bl++;
            if (b > 0) begin
                g = ((b % 256) == 0) ? 2 : 1;
                if (oq_cyc[b] - oq_cyc[b-1] != g) bg++;
            end
        end
        n_cmp++; if (bu != 0) begin n_bad++; $display("FAIL rr_tuser bad_beats %0d want 0", bu); end
        n_cmp++; if (bd != 0) begin n_bad++; $display("FAIL rr_tdata bad_beats %0d want 0", bd); end
        n_cmp++; if (bl != 0) begin n_bad++; $display("FAIL rr_tlast bad_beats %0d want 0", bl); end
        n_cmp++; if (bg != 0) begin n_bad++; $display("FAIL rr_gaps bad_gaps %0d want 0", bg); end
        n_cmp++; if (multi_rdy != 0) begin n_bad++; $display("FAIL rr_one_ready cycles %0d want 0", multi_rdy); end
        for (int k = 0; k < N; k++) en[k] = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_single();
        int t0, lat, bu, bd, bl;
        clear_out();
        set_src(0, 256, 256, 1, 1'b1, 1'b0);
        step();
        t0 = cyc;
        run_until(256, 400);
        n_cmp++; if (oq_dat.size() != 256) begin n_bad++; $display("FAIL single_count got %0d want 256", oq_dat.size()); end
        lat = (oq_cyc.size() > 0) ? oq_cyc[0] - t0 : -1;
        n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL single_latency got %0d want 2", lat); end
        bu = 0; bd = 0; bl = 0;
        for (int b = 0; b < oq_dat.size(); b++) begin
            if (oq_user[b] !== 8'd0) bu++;
            if (oq_dat[b] !== rep16(1)) bd++;
            if (oq_last[b] != (b == 255)) bl++;
        end
        n_cmp++; if (bu != 0) begin n_bad++; $display("FAIL single_tuser bad_beats %0d want 0", bu); end
        n_cmp++; if (bd != 0) begin n_bad++; $display("FAIL single_tdata bad_beats %0d want 0", bd); end
        n_cmp++; if (bl != 0) begin n_bad++; $display("FAIL single_tlast bad_beats %0d want 0", bl); end
        en[0] = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_fairness();
        logic [TW-1:0] want[4];
        logic [TW-1:0] got;
        int bu;
        want[0] = 8'd0; want[1] = 8'd2; want[2] = 8'd0; want[3] = 8'd0;
        clear_out();
        set_src(0, 24, 8, 1, 1'b1, 1'b0);
        run_until(2, 50);
        set_src(2, 8, 8, 3, 1'b1, 1'b0);
        run_until(32, 200);
        n_cmp++; if (oq_dat.size() != 32) begin n_bad++; $display("FAIL fair_count got %0d want 32", oq_dat.size()); end
        for (int p = 0; p < 4; p++) begin
            got = (oq_user.size() > p * 8) ? oq_user[p*8] : 8'hff;
            n_cmp++; if (got !== want[p]) begin n_bad++; $display("FAIL fair_order pkt %0d tuser %0d want %0d", p, got, want[p]); end
        end
        bu = 0;
        for (int b = 0; b < oq_user.size(); b++)
            if (oq_user[b] !== oq_user[b - (b % 8)]) bu++;
        n_cmp++; if (bu != 0) begin n_bad++; $display("FAIL fair_no_interleave bad_beats %0d want 0", bu); end
`ifndef PKT_LEN_CHECK_EN
        n_cmp++; if (pkt_err !== 1'b0) begin n_bad++; $display("FAIL fair_pkt_err got %b want 0", pkt_err); end
`endif
        en[0] = 1'b0;
        en[2] = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_backpressure();
        int bu, bd, bl;
        clear_out();
        stall_viol = 0;
        bp = 1'b1;
        set_src(2, 128, 128, 0, 1'b1, 1'b1);
        run_until(128, 600);
        bp = 1'b0;
        n_cmp++; if (oq_dat.size() != 128) begin n_bad++; $display("FAIL bp_count got %0d want 128", oq_dat.size()); end
        n_cmp++; if (sent[2] != 128) begin n_bad++; $display("FAIL bp_accepted got %0d want 128", sent[2]); end
        bu = 0; bd = 0; bl = 0;
        for (int b = 0; b < oq_dat.size(); b++) begin
            if (oq_user[b] !== 8'd2) bu++;
            if (oq_dat[b] !== BP_PAT) bd++;
            if (oq_last[b] != (b == 127)) bl++;
        end
        n_cmp++; if (bu != 0) begin n_bad++; $display("FAIL bp_tuser bad_beats %0d want 0", bu); end
        n_cmp++; if (bd != 0) begin n_bad++; $display("FAIL bp_tdata bad_beats %0d want 0", bd); end
        n_cmp++; if (bl != 0) begin n_bad++; $display("FAIL bp_tlast bad_beats %0d want 0", bl); end
        n_cmp++; if (stall_viol != 0) begin n_bad++; $display("FAIL bp_stable violations %0d want 0", stall_viol); end
        en[2] = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset_mid();
        logic [TW-1:0] u0, u4;
        logic [BW-1:0] d0;
        clear_out();
        set_src(0, 256, 256, 1, 1'b1, 1'b0);
        for (int k = 0; k < 400 && sent[0] < 100; k++) step();
        aresetn = 1'b0;
        #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_tvalid got %b want 0", m_tvalid); end
        n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL mid_rst_tlast got %b want 0", m_tlast); end
        n_cmp++; if (m_tdata !== '0) begin n_bad++; $display("FAIL mid_rst_tdata got %h want 0", m_tdata); end
        n_cmp++; if (m_tuser !== '0) begin n_bad++; $display("FAIL mid_rst_tuser got %h want 0", m_tuser); end
        n_cmp++; if (s_tready !== '0) begin n_bad++; $display("FAIL mid_rst_tready got %b want 0", s_tready); end
        en[0] = 1'b0;
        repeat (3) step();
        aresetn = 1'b1;
        clear_out();
        set_src(1, 4, 4, 2, 1'b1, 1'b0);
        set_src(3, 4, 4, 4, 1'b1, 1'b0);
        run_until(8, 100);
        repeat (4) step();
        n_cmp++; if (oq_dat.size() != 8) begin n_bad++; $display("FAIL mid_after_count got %0d want 8", oq_dat.size()); end
        u0 = (oq_user.size() > 0) ? oq_user[0] : 8'hff;
        d0 = (oq_dat.size() > 0) ? oq_dat[0] : '1;
        u4 = (oq_user.size() > 4) ? oq_user[4] : 8'hff;
        n_cmp++; if (u0 !== 8'd1) begin n_bad++; $display("FAIL mid_first_grant tuser %0d want 1", u0); end
        n_cmp++; if (d0 !== rep16(2)) begin n_bad++; $display("FAIL mid_first_data got %h want %h", d0, rep16(2)); end
        n_cmp++; if (u4 !== 8'd3) begin n_bad++; $display("FAIL mid_second_grant tuser %0d want 3", u4); end
        en[1] = 1'b0;
        en[3] = 1'b0;
        repeat (4) step();
    endtask

`ifdef PKT_LEN_CHECK_EN
    task automatic test_len_check();
        int bu, bl, gap;
        bit l255;
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        step();
        n_cmp++; if (pkt_err !== 1'b0) begin n_bad++; $display("FAIL len_err_clear got %b want 0", pkt_err); end
        clear_out();
        set_src(3, 300, 1, 4, 1'b0, 1'b0);
        run_until(300, 700);
        n_cmp++; if (oq_dat.size() != 300) begin n_bad++; $display("FAIL len_count got %0d want 300", oq_dat.size()); end
        l255 = (oq_last.size() > 255) ? oq_last[255] : 1'b0;
        n_cmp++; if (l255 != 1'b1) begin n_bad++; $display("FAIL len_forced_last got %b want 1", l255); end
        bu = 0; bl = 0;
        for (int b = 0; b < oq_dat.size(); b++) begin
            if (oq_user[b] !== 8'd3) bu++;
            if (b != 255 && oq_last[b]) bl++;
        end
        n_cmp++; if (bu != 0) begin n_bad++; $display("FAIL len_tuser bad_beats %0d want 0", bu); end
        n_cmp++; if (bl != 0) begin n_bad++; $display("FAIL len_extra_last bad_beats %0d want 0", bl); end
        gap = (oq_cyc.size() > 256) ? oq_cyc[256] - oq_cyc[255] : -1;
        n_cmp++; if (gap != 2) begin n_bad++; $display("FAIL len_rearb_gap got %0d want 2", gap); end
        n_cmp++; if (pkt_err !== 1'b1) begin n_bad++; $display("FAIL len_pkt_err got %b want 1", pkt_err); end
        en[3] = 1'b0;
        repeat (4) step();
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b0; tl_en[i] = 1'b0; pat_mode[i] = 1'b0;
            total[i] = 0; plen[i] = 1; sent[i] = 0; val[i] = 0;
        end
        test_reset();
        test_round_robin();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_mid();
`ifdef PKT_LEN_CHECK_EN
        test_len_check();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
